// File: rtl/motor_pkg.sv
// Shared definitions for the motor drive path: direction codes from the
// navigation FSM, drive state encoding and H-bridge polarity codes.
package motor_pkg;

  localparam logic [4:0] DIR_FORWARD  = 5'b00001;
  localparam logic [4:0] DIR_IDLE     = 5'b00010;
  localparam logic [4:0] DIR_BACKWARD = 5'b00100;
  localparam logic [4:0] DIR_LEFT     = 5'b01000;
  localparam logic [4:0] DIR_RIGHT    = 5'b10000;

  localparam logic [1:0] ST_STOP     = 2'd0;
  localparam logic [1:0] ST_DEADTIME = 2'd1;
  localparam logic [1:0] ST_RAMP     = 2'd2;
  localparam logic [1:0] ST_RUN      = 2'd3;

  localparam logic [1:0] POL_OFF = 2'b00;
  localparam logic [1:0] POL_FWD = 2'b10;
  localparam logic [1:0] POL_REV = 2'b01;

  typedef struct packed {
    logic [1:0] left;
    logic [1:0] right;
  } bridge_pol_t;

  function automatic logic is_one_hot(input logic [4:0] code);
    return (code != 5'b0) && ((code & (code - 5'd1)) == 5'b0);
  endfunction

  // Anything the navigation FSM sends that is not a clean one-hot code is parked as IDLE.
  function automatic logic [4:0] sanitize_dir(input logic [4:0] code);
    return is_one_hot(code) ? code : DIR_IDLE;
  endfunction

  function automatic bridge_pol_t decode_pol(input logic [4:0] code);
    bridge_pol_t pol;
    pol.left  = POL_OFF;
    pol.right = POL_OFF;
    case (code)
      DIR_FORWARD:  begin pol.left = POL_FWD; pol.right = POL_FWD; end
      DIR_BACKWARD: begin pol.left = POL_REV; pol.right = POL_REV; end
      DIR_LEFT:     begin pol.left = POL_REV; pol.right = POL_FWD; end
      DIR_RIGHT:    begin pol.left = POL_FWD; pol.right = POL_REV; end
      default:      ;
    endcase
    return pol;
  endfunction

endpackage

// File: rtl/motor_drive_ctrl_pwm_gen.sv
// Shared PWM generator: prescaled free-running counter compared against the
// current duty, with a registered enable output for both bridges.
module pwm_gen #(
  parameter int PWM_BITS     = 8,
  parameter int PWM_PRESCALE = 4
) (
  input  logic                clkin,
  input  logic                reset_n,
  input  logic                active,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_out
);

  localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_PRESCALE - 1);

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_out_q, pwm_out_d;

  always_comb begin
    pre_cnt_d = pre_cnt_q + PRE_W'(1);
    pwm_cnt_d = pwm_cnt_q;
    if (pre_cnt_q == PRE_LAST) begin
      pre_cnt_d = '0;
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    end
    // Strict less-than keeps duty 0 fully off and full-scale one tick short of always-on.
    pwm_out_d = active && (pwm_cnt_q < duty);
  end

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
      pwm_out_q <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;

endmodule

// File: rtl/motor_drive_ctrl.sv
// Dual H-bridge drive controller: decodes the navigation direction, sequences
// polarity changes through a bridge-off dead-time and a soft-start duty ramp.
module motor_drive_ctrl
  import motor_pkg::*;
#(
  parameter int PWM_BITS      = 8,
  parameter int PWM_PRESCALE  = 4,
  parameter int DEADTIME_CYC  = 1000,
  parameter int RAMP_STEP_CYC = 256
) (
  input  logic                clkin,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [4:0]          direction,
  input  logic [PWM_BITS-1:0] duty_max,
  output logic                ain1,
  output logic                ain2,
  output logic                bin1,
  output logic                bin2,
  output logic                pwma,
  output logic                pwmb,
  output logic                busy,
  output logic                fault
);

  localparam int DEAD_W = $clog2(DEADTIME_CYC + 1);
  localparam int RAMP_W = $clog2(RAMP_STEP_CYC + 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME_CYC - 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_STEP_CYC - 1);

  logic [4:0]          dir_q, dir_d;
  logic [PWM_BITS-1:0] duty_max_q, duty_max_d;
  logic                enable_q, enable_d;
  logic                fault_q, fault_d;

  logic [1:0]          state_q, state_d;
  logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
  logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
  logic [PWM_BITS-1:0] duty_cur_q, duty_cur_d;
  bridge_pol_t         drive_pol_q, drive_pol_d;
  bridge_pol_t         pins_q, pins_d;

  logic [4:0]          req;
  logic                req_idle;
  bridge_pol_t         req_pol;
  logic [PWM_BITS-1:0] target;
  logic                pol_change;
  logic                engaged;
  logic                pwm_out;

  always_comb begin
    dir_d      = direction;
    duty_max_d = duty_max;
    enable_d   = enable;
    fault_d    = !is_one_hot(direction);
  end

  always_comb begin
    req      = sanitize_dir(dir_q);
    req_idle = (req == DIR_IDLE);
    req_pol  = decode_pol(req);
    target   = '0;
    if (req == DIR_FORWARD || req == DIR_BACKWARD) begin
      target = duty_max_q;
    end else if (req == DIR_LEFT || req == DIR_RIGHT) begin
      target = duty_max_q >> 1;
    end
    pol_change = (req_pol != drive_pol_q);
  end

  always_comb begin
    state_d     = state_q;
    dead_cnt_d  = dead_cnt_q;
    ramp_cnt_d  = ramp_cnt_q;
    duty_cur_d  = duty_cur_q;
    drive_pol_d = drive_pol_q;

    if (!enable_q) begin
      state_d     = ST_STOP;
      dead_cnt_d  = '0;
      ramp_cnt_d  = '0;
      duty_cur_d  = '0;
      drive_pol_d = '0;
    end else begin
      case (state_q)
        ST_STOP: begin
          dead_cnt_d = '0;
          ramp_cnt_d = '0;
          duty_cur_d = '0;
          if (!req_idle) begin
            state_d = ST_DEADTIME;
          end
        end

        // The dead-time runs its full length; the request is only consulted at the end.
        ST_DEADTIME: begin
          duty_cur_d = '0;
          if (dead_cnt_q == DEAD_LAST) begin
            dead_cnt_d = '0;
            if (req_idle) begin
              state_d = ST_STOP;
            end else begin
              state_d     = ST_RAMP;
              drive_pol_d = req_pol;
              ramp_cnt_d  = '0;
            end
          end else begin
            dead_cnt_d = dead_cnt_q + DEAD_W'(1);
          end
        end

        ST_RAMP: begin
          if (req_idle || pol_change) begin
            state_d    = ST_DEADTIME;
            dead_cnt_d = '0;
            ramp_cnt_d = '0;
            duty_cur_d = '0;
          end else if (duty_cur_q >= target) begin
            state_d    = ST_RUN;
            duty_cur_d = target;
            ramp_cnt_d = '0;
          end else if (ramp_cnt_q == RAMP_LAST) begin
            ramp_cnt_d = '0;
            duty_cur_d = duty_cur_q + PWM_BITS'(1);
          end else begin
            ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
          end
        end

        ST_RUN: begin
          if (req_idle || pol_change) begin
            state_d    = ST_DEADTIME;
            dead_cnt_d = '0;
            ramp_cnt_d = '0;
            duty_cur_d = '0;
          end else if (target > duty_cur_q) begin
            state_d    = ST_RAMP;
            ramp_cnt_d = '0;
          end else begin
            duty_cur_d = target;
          end
        end

        default: begin
          state_d = ST_STOP;
        end
      endcase
    end
  end

  // Pins follow the registered state, so they drop one edge after the FSM leaves RAMP/RUN.
  always_comb begin
    engaged = (state_q == ST_RAMP) || (state_q == ST_RUN);
    pins_d  = engaged ? drive_pol_q : '0;
  end

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      dir_q       <= '0;
      duty_max_q  <= '0;
      enable_q    <= 1'b0;
      fault_q     <= 1'b0;
      state_q     <= ST_STOP;
      dead_cnt_q  <= '0;
      ramp_cnt_q  <= '0;
      duty_cur_q  <= '0;
      drive_pol_q <= '0;
      pins_q      <= '0;
    end else begin
      dir_q       <= dir_d;
      duty_max_q  <= duty_max_d;
      enable_q    <= enable_d;
      fault_q     <= fault_d;
      state_q     <= state_d;
      dead_cnt_q  <= dead_cnt_d;
      ramp_cnt_q  <= ramp_cnt_d;
      duty_cur_q  <= duty_cur_d;
      drive_pol_q <= drive_pol_d;
      pins_q      <= pins_d;
    end
  end

  pwm_gen #(
    .PWM_BITS     (PWM_BITS),
    .PWM_PRESCALE (PWM_PRESCALE)
  ) u_pwm_gen (
    .clkin   (clkin),
    .reset_n (reset_n),
    .active  (engaged),
    .duty    (duty_cur_q),
    .pwm_out (pwm_out)
  );

  assign ain1  = pins_q.left[1];
  assign ain2  = pins_q.left[0];
  assign bin1  = pins_q.right[1];
  assign bin2  = pins_q.right[0];
  assign pwma  = pwm_out;
  assign pwmb  = pwm_out;
  assign busy  = (state_q == ST_DEADTIME) || (state_q == ST_RAMP);
  assign fault = fault_q;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Testbench for motor_drive_ctrl: directed scenarios plus random direction/duty
// traffic, all compared against a behavioural timeline model of the drive.
module tb_motor_drive_ctrl;
  import motor_pkg::*;

  localparam int PWM_BITS      = 8;
  localparam int PWM_PRESCALE  = 1;
  localparam int DEADTIME_CYC  = 4;
  localparam int RAMP_STEP_CYC = 2;
  localparam int PERIOD        = 256;

  logic       clkin = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [4:0] direction = DIR_IDLE;
  logic [7:0] duty_max = 8'd0;
  logic ain1, ain2, bin1, bin2, pwma, pwmb, busy, fault;

  always #5 clkin = ~clkin;

  motor_drive_ctrl #(
    .PWM_BITS      (PWM_BITS),
    .PWM_PRESCALE  (PWM_PRESCALE),
    .DEADTIME_CYC  (DEADTIME_CYC),
    .RAMP_STEP_CYC (RAMP_STEP_CYC)
  ) dut (
    .clkin     (clkin),
    .reset_n   (reset_n),
    .enable    (enable),
    .direction (direction),
    .duty_max  (duty_max),
    .ain1      (ain1),
    .ain2      (ain2),
    .bin1      (bin1),
    .bin2      (bin2),
    .pwma      (pwma),
    .pwmb      (pwmb),
    .busy      (busy),
    .fault     (fault)
  );

  wire [7:0] dut_vec = {ain1, ain2, bin1, bin2, pwma, pwmb, busy, fault};
  wire [3:0] dut_pins = {ain1, ain2, bin1, bin2};

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a drive "mode" with countdown timers; motor polarity as signed numbers.
  typedef enum int {M_OFF, M_WAIT, M_SOFT, M_STEADY} mode_e;
  mode_e      m_mode;
  int         m_wait_left, m_soft_timer, m_duty, m_lp, m_rp;
  int         m_out_l, m_out_r, m_in_duty;
  bit         m_out_pwm, m_fault, m_in_en;
  logic [4:0] m_in_dir;
  longint     m_tick;

  function automatic bit legal(input logic [4:0] d);
    return $countones(d) == 1;
  endfunction

  function automatic int sign_left(input logic [4:0] d);
    if (d == DIR_FORWARD || d == DIR_RIGHT) return 1;
    if (d == DIR_BACKWARD || d == DIR_LEFT) return -1;
    return 0;
  endfunction

  function automatic int sign_right(input logic [4:0] d);
    if (d == DIR_FORWARD || d == DIR_LEFT) return 1;
    if (d == DIR_BACKWARD || d == DIR_RIGHT) return -1;
    return 0;
  endfunction

  function automatic logic [1:0] pol_bits(input int s);
    if (s > 0) return 2'b10;
    if (s < 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [7:0] model_vec();
    return {pol_bits(m_out_l), pol_bits(m_out_r), m_out_pwm, m_out_pwm,
            (m_mode == M_WAIT || m_mode == M_SOFT), m_fault};
  endfunction

  task automatic model_edge();
    logic [4:0] req;
    int rl, rr, tgt;
    bit idle, engaged;
    if (!reset_n) begin
      m_mode = M_OFF; m_wait_left = 0; m_soft_timer = 0; m_duty = 0;
      m_lp = 0; m_rp = 0; m_out_l = 0; m_out_r = 0; m_out_pwm = 0;
      m_fault = 0; m_in_en = 0; m_in_dir = 5'b0; m_in_duty = 0; m_tick = 0;
      return;
    end
    engaged   = (m_mode == M_SOFT || m_mode == M_STEADY);
    m_out_l   = engaged ? m_lp : 0;
    m_out_r   = engaged ? m_rp : 0;
    m_out_pwm = engaged && (int'(m_tick % PERIOD) < m_duty);
    m_tick++;

    req  = legal(m_in_dir) ? m_in_dir : DIR_IDLE;
    idle = (req == DIR_IDLE);
    rl   = sign_left(req);
    rr   = sign_right(req);
    if (req == DIR_FORWARD || req == DIR_BACKWARD) tgt = m_in_duty;
    else if (req == DIR_LEFT || req == DIR_RIGHT) tgt = m_in_duty / 2;
    else tgt = 0;

    if (!m_in_en) begin
      m_mode = M_OFF; m_duty = 0; m_lp = 0; m_rp = 0;
    end else begin
      case (m_mode)
        M_OFF: begin
          m_duty = 0;
          if (!idle) begin m_mode = M_WAIT; m_wait_left = DEADTIME_CYC; end
        end
        M_WAIT: begin
          m_duty = 0;
          if (m_wait_left == 1) begin
            if (idle) m_mode = M_OFF;
            else begin m_mode = M_SOFT; m_lp = rl; m_rp = rr; m_soft_timer = RAMP_STEP_CYC; end
          end else m_wait_left--;
        end
        M_SOFT: begin
          if (idle || rl != m_lp || rr != m_rp) begin
            m_mode = M_WAIT; m_wait_left = DEADTIME_CYC; m_duty = 0;
          end else if (m_duty >= tgt) begin
            m_duty = tgt; m_mode = M_STEADY;
          end else begin
            m_soft_timer--;
            if (m_soft_timer == 0) begin m_duty++; m_soft_timer = RAMP_STEP_CYC; end
          end
        end
        M_STEADY: begin
          if (idle || rl != m_lp || rr != m_rp) begin
            m_mode = M_WAIT; m_wait_left = DEADTIME_CYC; m_duty = 0;
          end else if (tgt > m_duty) begin
            m_mode = M_SOFT; m_soft_timer = RAMP_STEP_CYC;
          end else m_duty = tgt;
        end
        default: m_mode = M_OFF;
      endcase
    end

    m_in_dir  = direction;
    m_in_duty = duty_max;
    m_in_en   = enable;
    m_fault   = !legal(direction);
  endtask

  task automatic step_cycle();
    @(posedge clkin);
    model_edge();
    @(negedge clkin);
  endtask

  task automatic test_reset();
    int zero_busy, highs;
    bit driven;
    reset_n = 1'b0; enable = 1'b1; direction = DIR_FORWARD; duty_max = 8'd10;
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      vectors++;
      if (dut_vec !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL reset_hold got=%b want=00000000", dut_vec);
      end
    end
    reset_n = 1'b1;
    zero_busy = 0; driven = 0;
    for (int i = 0; i < 20 && !driven; i++) begin
      step_cycle();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL reset_release got=%b want=%b", dut_vec, model_vec());
      end
      if (busy === 1'b1 && dut_pins === 4'b0000) zero_busy++;
      if (dut_pins === 4'b1010) driven = 1;
    end
    vectors++;
    if (!driven || zero_busy < DEADTIME_CYC) begin
      miscompares++;
      $display("[TB] FAIL reset_deadtime got driven=%0d off_cycles=%0d want driven=1 off_cycles>=%0d",
               driven, zero_busy, DEADTIME_CYC);
    end
    for (int i = 0; i < 60 && busy !== 1'b0; i++) begin
      step_cycle();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL reset_ramp got=%b want=%b", dut_vec, model_vec());
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ramp_done got busy=%b want 0", busy);
    end
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step_cycle();
      if (pwma === 1'b1) highs++;
    end
    vectors++;
    if (highs != 10) begin
      miscompares++;
      $display("[TB] FAIL reset_pwm_duty got=%0d want=10", highs);
    end
  endtask

  task automatic test_turn();
    int highs;
    direction = DIR_RIGHT;
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL turn_entry got=%b want=%b", dut_vec, model_vec());
      end
    end
    vectors++;
    if ({dut_pins, pwma, pwmb} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL turn_off_k2 got pins=%b pwm=%b%b want all 0", dut_pins, pwma, pwmb);
    end
    for (int i = 0; i < 80 && busy !== 1'b0; i++) begin
      step_cycle();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL turn_ramp got=%b want=%b", dut_vec, model_vec());
      end
    end
    vectors++;
    if (busy !== 1'b0 || dut_pins !== 4'b1001) begin
      miscompares++;
      $display("[TB] FAIL turn_pins got busy=%b pins=%b want busy=0 pins=1001", busy, dut_pins);
    end
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step_cycle();
      if (pwmb === 1'b1) highs++;
    end
    vectors++;
    if (highs != 5) begin
      miscompares++;
      $display("[TB] FAIL turn_pwm_duty got=%0d want=5", highs);
    end
  endtask

  task automatic test_reversal();
    logic [1:0] last_l;
    int zr;
    bit hit;
    last_l = {ain1, ain2}; zr = 0; hit = 0;
    direction = DIR_FORWARD;
    for (int i = 0; i < 80 && !hit; i++) begin
      step_cycle();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL rev_fwd got=%b want=%b", dut_vec, model_vec());
      end
      if ({ain1, ain2} == 2'b00) zr++;
      else begin
        if (last_l != 2'b00 && {ain1, ain2} != last_l) begin
          vectors++;
          if (zr < DEADTIME_CYC) begin
            miscompares++;
            $display("[TB] FAIL rev_gap got=%0d want>=%0d", zr, DEADTIME_CYC);
          end
        end
        last_l = {ain1, ain2}; zr = 0;
      end
      if (m_mode == M_SOFT && m_duty == 3) hit = 1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("[TB] FAIL rev_reach_duty3 got=%0d want=3", m_duty);
    end
    direction = DIR_BACKWARD;
    for (int i = 0; i < 100; i++) begin
      step_cycle();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL rev_bwd got=%b want=%b", dut_vec, model_vec());
      end
      if (i == 2) begin
        vectors++;
        if (pwma !== 1'b0 || pwmb !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL rev_pwm_k2 got=%b%b want=00", pwma, pwmb);
        end
      end
      if ({ain1, ain2} == 2'b00) zr++;
      else begin
        if (last_l != 2'b00 && {ain1, ain2} != last_l) begin
          vectors++;
          if (zr < DEADTIME_CYC) begin
            miscompares++;
            $display("[TB] FAIL rev_gap got=%0d want>=%0d", zr, DEADTIME_CYC);
          end
        end
        last_l = {ain1, ain2}; zr = 0;
      end
      if (i > 4 && busy === 1'b0) break;
    end
    vectors++;
    if (busy !== 1'b0 || dut_pins !== 4'b0101) begin
      miscompares++;
      $display("[TB] FAIL rev_final got busy=%b pins=%b want busy=0 pins=0101", busy, dut_pins);
    end
  endtask

  task automatic test_duty_change();
    int highs, ramp_len;
    duty_max = 8'd4;
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL duty_down got=%b want=%b", dut_vec, model_vec());
      end
    end
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step_cycle();
      if (pwma === 1'b1) highs++;
    end
    vectors++;
    if (highs != 4 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL duty_down_pwm got=%0d busy=%b want=4 busy=0", highs, busy);
    end
    duty_max = 8'd8;
    ramp_len = 0;
    for (int i = 0; i < 40; i++) begin
      step_cycle();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL duty_up got=%b want=%b", dut_vec, model_vec());
      end
      if (busy === 1'b1) ramp_len++;
      else if (ramp_len > 0) break;
    end
    vectors++;
    if (ramp_len != 4 * RAMP_STEP_CYC + 1) begin
      miscompares++;
      $display("[TB] FAIL duty_up_len got=%0d want=%0d", ramp_len, 4 * RAMP_STEP_CYC + 1);
    end
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step_cycle();
      if (pwma === 1'b1) highs++;
    end
    vectors++;
    if (highs != 8) begin
      miscompares++;
      $display("[TB] FAIL duty_up_pwm got=%0d want=8", highs);
    end
  endtask

  task automatic test_kill_illegal();
    bit pins_seen;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL kill got=%b want=%b", dut_vec, model_vec());
      end
    end
    vectors++;
    if (dut_vec !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL kill_k2 got=%b want=00000000", dut_vec);
    end
    enable = 1'b1;
    direction = 5'b00011;
    step_cycle();
    vectors++;
    if (fault !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL illegal_fault got=%b want=1", fault);
    end
    for (int i = 0; i < 6; i++) step_cycle();
    vectors++;
    if (busy !== 1'b0 || dut_pins !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL illegal_stop got busy=%b pins=%b want 0/0000", busy, dut_pins);
    end
    direction = DIR_FORWARD;
    for (int i = 0; i < 10 && busy !== 1'b1; i++) step_cycle();
    direction = 5'b00011;
    pins_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step_cycle();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL illegal_dead got=%b want=%b", dut_vec, model_vec());
      end
      if (dut_pins !== 4'b0) pins_seen = 1;
    end
    vectors++;
    if (pins_seen || busy !== 1'b0 || fault !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL illegal_to_stop got pins_seen=%0d busy=%b fault=%b want 0/0/1",
               pins_seen, busy, fault);
    end
    direction = DIR_IDLE;
    step_cycle();
    vectors++;
    if (fault !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fault_clear got=%b want=0", fault);
    end
  endtask

  task automatic test_mid_deadtime();
    int steps;
    bit seen;
    duty_max = 8'd12;
    direction = DIR_FORWARD;
    for (int i = 0; i < 10 && busy !== 1'b1; i++) step_cycle();
    direction = DIR_IDLE;
    step_cycle();
    direction = DIR_LEFT;
    steps = 1; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step_cycle();
      steps++;
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL mid_dead got=%b want=%b", dut_vec, model_vec());
      end
      if (dut_pins !== 4'b0) seen = 1;
    end
    vectors++;
    if (!seen || steps != DEADTIME_CYC + 1 || dut_pins !== 4'b0110) begin
      miscompares++;
      $display("[TB] FAIL mid_dead_pins got steps=%0d pins=%b want steps=%0d pins=0110",
               steps, dut_pins, DEADTIME_CYC + 1);
    end
  endtask

  task automatic test_random();
    logic [4:0] codes [5];
    logic [1:0] last_l, last_r;
    int zr_l, zr_r;
    codes[0] = DIR_FORWARD; codes[1] = DIR_IDLE; codes[2] = DIR_BACKWARD;
    codes[3] = DIR_LEFT; codes[4] = DIR_RIGHT;
    last_l = {ain1, ain2}; last_r = {bin1, bin2}; zr_l = 0; zr_r = 0;
    for (int n = 0; n < 4000; n++) begin
      reset_n = ($urandom_range(0, 1499) != 0);
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 7) == 0) direction = 5'($urandom_range(0, 31));
        else direction = codes[$urandom_range(0, 4)];
      end
      if ($urandom_range(0, 59) == 0)
        duty_max = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 40));
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      step_cycle();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL random n=%0d got=%b want=%b", n, dut_vec, model_vec());
      end
      if ({ain1, ain2} == 2'b00) zr_l++;
      else begin
        if (last_l != 2'b00 && {ain1, ain2} != last_l) begin
          vectors++;
          if (zr_l < DEADTIME_CYC) begin
            miscompares++;
            $display("[TB] FAIL random_gap_a got=%0d want>=%0d", zr_l, DEADTIME_CYC);
          end
        end
        last_l = {ain1, ain2}; zr_l = 0;
      end
      if ({bin1, bin2} == 2'b00) zr_r++;
      else begin
        if (last_r != 2'b00 && {bin1, bin2} != last_r) begin
          vectors++;
          if (zr_r < DEADTIME_CYC) begin
            miscompares++;
            $display("[TB] FAIL random_gap_b got=%0d want>=%0d", zr_r, DEADTIME_CYC);
          end
        end
        last_r = {bin1, bin2}; zr_r = 0;
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_turn();
    test_reversal();
    test_duty_change();
    test_kill_illegal();
    test_mid_deadtime();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/motor_drive_ctrl.md
Name: motor_drive_ctrl

Overview:
- Sits between the one-hot `direction` bus of the navigation FSM and the dual H-bridge driver (left motor A, right motor B).
- Decodes the requested direction into per-motor polarity.
- Sequences every polarity change through a bridge-off dead-time, then a soft-start duty ramp.
- Generates the PWM for both bridge enables.
- Global `enable` acts as a kill that stops the bridge.

Parameters:
- PWM_BITS, 8, width of duty and PWM counter; PWM period = 2^PWM_BITS ticks.
- PWM_PRESCALE, 4, clkin cycles per PWM tick (≥1).
- DEADTIME_CYC, 1000, clkin cycles with bridge off between polarity changes (≥1).
- RAMP_STEP_CYC, 256, clkin cycles per +1 duty increment during ramp (≥1).

Ports:
- clkin  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  1 = drive allowed; 0 = force STOP
- direction  in  5  one-hot request: FORWARD 00001, IDLE 00010, BACKWARD 00100, LEFT 01000, RIGHT 10000
- duty_max  in  PWM_BITS  straight-line duty target
- ain1, ain2  out  1  left bridge polarity (10 fwd, 01 rev, 00 off)
- bin1, bin2  out  1  right bridge polarity
- pwma, pwmb  out  1  left/right bridge PWM enable
- busy  out  1  high in DEADTIME or RAMP
- fault  out  1  high while direction is not exactly one-hot

Behaviour:
- Reset (reset_n=0 at a clkin edge): state STOP; all outputs 0; duty_cur, dead/ramp/prescale/PWM counters 0.
- Input stage: direction, duty_max and enable are registered once (1-cycle latency).
  - Non-one-hot or zero direction is treated as IDLE.
  - fault = registered "not one-hot"; high while the condition persists.
- Decode (pol L,R): FORWARD (+,+); BACKWARD (−,−); LEFT (−,+); RIGHT (+,−); IDLE none.
- Duty target: duty_max for FORWARD/BACKWARD; duty_max>>1 for LEFT/RIGHT.
- STOP: polarity pins 00; pwm 0; duty_cur 0.
  - Registered request ≠ IDLE and enable=1 → DEADTIME.
- DEADTIME: pins 00; pwm 0; duty_cur 0; counter runs 0..DEADTIME_CYC−1.
  - Latest target is re-captured every cycle; the counter is not restarted by a request change.
  - At terminal count: target IDLE → STOP; else drive target polarity pins → RAMP.
- RAMP: duty_cur +1 every RAMP_STEP_CYC cycles. When duty_cur == target → RUN.
  - Target 0 → RUN on the next cycle.
- RUN: hold duty_cur.
  - Target rises → RAMP.
  - Target falls → duty_cur snaps to the new target in the next cycle, stays in RUN.
- Direction change in RAMP or RUN:
  - IDLE or new polarity → DEADTIME; pins 00 and pwm 0 on the next edge.
  - Change between same-polarity codes cannot occur; every non-IDLE code has a distinct polarity.
- enable=0 (registered) in any state → STOP next edge. STOP always exits through DEADTIME.
- PWM:
  - Prescaler counts 0..PWM_PRESCALE−1; each wrap advances pwm_cnt (wraps at 2^PWM_BITS−1).
  - pwma = pwmb = registered (pwm_cnt < duty_cur) while in RAMP/RUN, else 0.
  - Duty 0 → never high; duty 255 (8-bit) → high 255 of 256 ticks.
- Output latency: a direction edge sampled at clk k shows on pins/pwm at clk k+2.
- No state ever drives opposite polarity without ≥DEADTIME_CYC cycles of pins 00 in between.
- busy = (state == DEADTIME || state == RAMP).

Decomposition:
- Shared package motor_pkg:
  - direction one-hot localparams (FORWARD, IDLE, BACKWARD, LEFT, RIGHT), shared with the navigation FSM;
  - drive state encoding (STOP, DEADTIME, RAMP, RUN);
  - polarity codes (OFF 2'b00, FWD 2'b10, REV 2'b01).
- One sub-module: pwm_gen (prescaler + PWM_BITS counter + compare), one instance shared by both bridges.

Test Plan (PWM_PRESCALE=1, DEADTIME_CYC=4, RAMP_STEP_CYC=2, PWM_BITS=8):
- Reset: hold reset_n=0 3 cycles with direction=FORWARD, enable=1 → all outputs 0. Release → DEADTIME for 4 cycles (busy=1, pins 00), then ain/bin=10/10. duty_max=10 → duty_cur reaches 10 after 20 cycles, busy drops, pwma high 10 of every 256 cycles.
- Turn: in RUN at duty 10, direction=RIGHT → pins 00, pwm 0 at k+2 for 4 cycles. Then ain=10, bin=01, ramp to 5.
- Reversal mid-ramp: FORWARD ramping at duty 3, direction=BACKWARD → pwm 0 at k+2, pins never 10→01 without 4 cycles of 00, duty restarts from 0.
- Duty change in RUN: duty_max 10→4 → duty_cur 4 next cycle, state RUN. 4→8 → RAMP, 8 reached after 8 cycles.
- Kill/illegal: enable=0 in RUN → STOP, all outputs 0 at k+2. direction=5'b00011 → fault=1, treated as IDLE (DEADTIME→STOP). Valid code → fault=0.
- Mid-deadtime change: FORWARD→IDLE then LEFT 2 cycles into DEADTIME → DEADTIME ends at its original count, pins ain=01, bin=10.
